// File: rtl/hazard_pkg.sv
// Shared constants for the hazard control unit: MIPS opcode/funct
// encodings consumed by the decoder and the stall FSM state encoding.
package hazard_pkg;

   localparam logic [5:0] RTYPE     = 6'b000000;
   localparam logic [5:0] BGEZ_BLTZ = 6'b000001;
   localparam logic [5:0] J         = 6'b000010;
   localparam logic [5:0] JAL       = 6'b000011;
   localparam logic [5:0] BEQ       = 6'b000100;
   localparam logic [5:0] BNE       = 6'b000101;
   localparam logic [5:0] BLEZ      = 6'b000110;
   localparam logic [5:0] BGTZ      = 6'b000111;
   localparam logic [5:0] SB        = 6'b101000;
   localparam logic [5:0] SH        = 6'b101001;
   localparam logic [5:0] SW        = 6'b101011;
   localparam logic [5:0] JR_FUNCT  = 6'b001000;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      BR_WAIT    = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_decode.sv
// Operand-usage and control-flow decode of the instruction held in IF/ID.
// Unknown opcodes decode as a plain rs consumer that is not control flow.
module hazard_decode
   import hazard_pkg::*;
(
   input  logic [31:0] IFID_Instruction,
   output logic        uses_rs,
   output logic        uses_rt,
   output logic        is_ctrl,
   output logic [4:0]  rs,
   output logic [4:0]  rt
);

   logic [5:0] opcode_s;
   logic [5:0] funct_s;
   logic       unused_s;

   assign opcode_s = IFID_Instruction[31:26];
   assign funct_s  = IFID_Instruction[5:0];
   assign rs       = IFID_Instruction[25:21];
   assign rt       = IFID_Instruction[20:16];
   assign unused_s = ^IFID_Instruction[15:6];

   // Classify the opcode into register usage and control-flow flags.
   always_comb begin
      uses_rs = 1'b1;
      uses_rt = 1'b0;
      is_ctrl = 1'b0;
      case (opcode_s)
         RTYPE: begin
            uses_rt = 1'b1;
            if (funct_s == JR_FUNCT) begin
               is_ctrl = 1'b1;
            end else begin
               is_ctrl = 1'b0;
            end
         end
         BEQ, BNE: begin
            uses_rt = 1'b1;
            is_ctrl = 1'b1;
         end
         BGEZ_BLTZ, BLEZ, BGTZ: begin
            is_ctrl = 1'b1;
         end
         J, JAL: begin
            uses_rs = 1'b0;
            is_ctrl = 1'b1;
         end
         SW, SH, SB: begin
            uses_rt = 1'b1;
         end
         default: begin
            uses_rs = 1'b1;
            uses_rt = 1'b0;
            is_ctrl = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use and control hazard unit for the 5-stage MIPS pipeline.
// A counter-driven FSM stretches load bubbles and branch fetch suppression;
// outputs are combinational so a stall acts in the cycle it is detected.
// Optional build macro HAZARD_STATS_EN adds saturating stall-cycle counters.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT   = 1,
   parameter int BRANCH_LAT = 2,
   parameter int STATS_W    = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_rt,
   input  logic [31:0] IFID_Instruction,
   input  logic        EX_BranchResolved,
`ifdef HAZARD_STATS_EN
   output logic [STATS_W-1:0] load_stall_cycles,
   output logic [STATS_W-1:0] branch_stall_cycles,
`endif
   output logic        hold_PC,
   output logic        hold_IFID,
   output logic        flush_IFID,
   output logic        flush_IDEX,
   output logic        busy
);

   if (LOAD_LAT < 1 || LOAD_LAT > 7 || BRANCH_LAT < 1 || BRANCH_LAT > 7 || STATS_W < 1) begin : g_bad_param
      $error("hazard_control_unit: parameter out of range");
   end

   logic        uses_rs_s, uses_rt_s, is_ctrl_s;
   logic [4:0]  rs_s, rt_s;
   logic        load_hz_s;
   logic        load_hold_s, br_hold_s;
   hz_state_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;

   hazard_decode u_decode (
      .IFID_Instruction (IFID_Instruction),
      .uses_rs          (uses_rs_s),
      .uses_rt          (uses_rt_s),
      .is_ctrl          (is_ctrl_s),
      .rs               (rs_s),
      .rt               (rt_s)
   );

   // A load hazard needs a real ($zero excluded) register the consumer reads.
   always_comb begin
      load_hz_s = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                  ((uses_rs_s && (rs_s == IDEX_rt)) || (uses_rt_s && (rt_s == IDEX_rt)));
   end

   // Next-state, counter and stall outputs; Reset forces everything quiet.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_PC     = 1'b0;
      hold_IFID   = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEX  = 1'b0;
      busy        = 1'b0;
      load_hold_s = 1'b0;
      br_hold_s   = 1'b0;
      if (Reset) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
      end else begin
         busy = (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (load_hz_s) begin
                  hold_PC     = 1'b1;
                  hold_IFID   = 1'b1;
                  flush_IDEX  = 1'b1;
                  load_hold_s = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = LOAD_STALL;
                     cnt_d   = 3'(LOAD_LAT - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end else if (is_ctrl_s) begin
                  hold_PC    = 1'b1;
                  flush_IFID = 1'b1;
                  br_hold_s  = 1'b1;
                  if (BRANCH_LAT > 1) begin
                     state_d = BR_WAIT;
                     cnt_d   = 3'(BRANCH_LAT - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD_STALL: begin
               hold_PC     = 1'b1;
               hold_IFID   = 1'b1;
               flush_IDEX  = 1'b1;
               load_hold_s = 1'b1;
               if (cnt_q <= 3'd1) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d   = cnt_q - 3'd1;
               end
            end
            BR_WAIT: begin
               flush_IFID = 1'b1;
               if (EX_BranchResolved) begin
                  // Let the resolved target land in the PC this cycle.
                  hold_PC = 1'b0;
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  hold_PC   = 1'b1;
                  br_hold_s = 1'b1;
                  if (cnt_q <= 3'd1) begin
                     state_d = IDLE;
                     cnt_d   = 3'd0;
                  end else begin
                     cnt_d   = cnt_q - 3'd1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // State and counter registers.
   always_ff @(posedge Clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

`ifdef HAZARD_STATS_EN
   logic [STATS_W-1:0] load_cnt_q, load_cnt_d, br_cnt_q, br_cnt_d;

   // Saturating per-class stall-cycle counts.
   always_comb begin
      load_cnt_d = load_cnt_q;
      br_cnt_d   = br_cnt_q;
      if (Reset) begin
         load_cnt_d = {STATS_W{1'b0}};
         br_cnt_d   = {STATS_W{1'b0}};
      end else begin
         if (load_hold_s && (load_cnt_q != {STATS_W{1'b1}})) begin
            load_cnt_d = load_cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
         end else begin
            load_cnt_d = load_cnt_q;
         end
         if (br_hold_s && (br_cnt_q != {STATS_W{1'b1}})) begin
            br_cnt_d = br_cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
         end else begin
            br_cnt_d = br_cnt_q;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge Clk) begin
      load_cnt_q <= load_cnt_d;
      br_cnt_q   <= br_cnt_d;
   end

   assign load_stall_cycles   = load_cnt_q;
   assign branch_stall_cycles = br_cnt_q;
`else
   logic unused_stats_s;
   assign unused_stats_s = load_hold_s ^ br_hold_s;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: DUT A (LOAD_LAT=1, BRANCH_LAT=2), DUT B (LOAD_LAT=3,
// BRANCH_LAT=3) share inputs. Outputs compared as
// {hold_PC, hold_IFID, flush_IFID, flush_IDEX, busy}.
module tb_hazard_control_unit;

   logic        Clk;
   logic        Reset;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_rt;
   logic [31:0] IFID_Instruction;
   logic        EX_BranchResolved;
   logic        a_hold_PC, a_hold_IFID, a_flush_IFID, a_flush_IDEX, a_busy;
   logic        b_hold_PC, b_hold_IFID, b_flush_IFID, b_flush_IDEX, b_busy;
`ifdef HAZARD_STATS_EN
   logic [15:0] a_lsc, a_bsc, b_lsc, b_bsc;
`endif

   int n_pass  = 0;
   int n_total = 0;

   hazard_control_unit #(.LOAD_LAT(1), .BRANCH_LAT(2), .STATS_W(16)) dut_a (
      .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .IFID_Instruction(IFID_Instruction), .EX_BranchResolved(EX_BranchResolved),
`ifdef HAZARD_STATS_EN
      .load_stall_cycles(a_lsc), .branch_stall_cycles(a_bsc),
`endif
      .hold_PC(a_hold_PC), .hold_IFID(a_hold_IFID), .flush_IFID(a_flush_IFID),
      .flush_IDEX(a_flush_IDEX), .busy(a_busy)
   );

   hazard_control_unit #(.LOAD_LAT(3), .BRANCH_LAT(3), .STATS_W(16)) dut_b (
      .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
      .IFID_Instruction(IFID_Instruction), .EX_BranchResolved(EX_BranchResolved),
`ifdef HAZARD_STATS_EN
      .load_stall_cycles(b_lsc), .branch_stall_cycles(b_bsc),
`endif
      .hold_PC(b_hold_PC), .hold_IFID(b_hold_IFID), .flush_IFID(b_flush_IFID),
      .flush_IDEX(b_flush_IDEX), .busy(b_busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   localparam logic [31:0] ADD  = 32'h010A4820;  // add $9,$8,$10
   localparam logic [31:0] ADDZ = 32'h00004820;  // add $9,$0,$0
   localparam logic [31:0] JMP  = 32'h09000000;  // j, rs field = 8
   localparam logic [31:0] BEQI = 32'h11090004;  // beq $8,$9
   localparam logic [31:0] SWI  = 32'hAD280000;  // sw $8,0($9)
   localparam logic [31:0] LWI  = 32'h8D280000;  // lw $8,0($9)
   localparam logic [31:0] JRI  = 32'h01000008;  // jr $8
   localparam logic [31:0] ADDI = 32'h21090000;  // addi $9,$8,0
   localparam logic [31:0] BGEZ = 32'h05010003;  // bgez $8
   localparam logic [31:0] BLEZ = 32'h19000002;  // blez $8
   localparam logic [31:0] NOP  = 32'h00000000;

   localparam logic [4:0] O_NONE = 5'b00000;
   localparam logic [4:0] O_LD   = 5'b11010;
   localparam logic [4:0] O_LDB  = 5'b11011;
   localparam logic [4:0] O_BR   = 5'b10100;
   localparam logic [4:0] O_BRB  = 5'b10101;
   localparam logic [4:0] O_REL  = 5'b00101;

   typedef struct {
      logic        mr;
      logic [4:0]  rt;
      logic [31:0] ins;
      logic [4:0]  exp;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk16(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
`endif

   task automatic cyc(input logic rst, input logic mr, input logic [4:0] rt,
                      input logic [31:0] ins, input logic res,
                      input logic [4:0] ea, input logic [4:0] eb, input string tag);
      Reset             = rst;
      IDEX_MemRead      = mr;
      IDEX_rt           = rt;
      IFID_Instruction  = ins;
      EX_BranchResolved = res;
      @(negedge Clk);
      chk({tag, "/A"}, {a_hold_PC, a_hold_IFID, a_flush_IFID, a_flush_IDEX, a_busy}, ea);
      chk({tag, "/B"}, {b_hold_PC, b_hold_IFID, b_flush_IFID, b_flush_IDEX, b_busy}, eb);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd8,  ADD,  O_LD};
      vecs[1]  = '{1'b0, 5'd8,  ADD,  O_NONE};
      vecs[2]  = '{1'b1, 5'd10, ADD,  O_LD};
      vecs[3]  = '{1'b1, 5'd8,  JMP,  O_BR};
      vecs[4]  = '{1'b1, 5'd0,  ADDZ, O_NONE};
      vecs[5]  = '{1'b0, 5'd0,  BEQI, O_BR};
      vecs[6]  = '{1'b1, 5'd9,  BEQI, O_LD};
      vecs[7]  = '{1'b1, 5'd8,  SWI,  O_LD};
      vecs[8]  = '{1'b1, 5'd8,  LWI,  O_NONE};
      vecs[9]  = '{1'b0, 5'd0,  JRI,  O_BR};
      vecs[10] = '{1'b1, 5'd8,  JRI,  O_LD};
      vecs[11] = '{1'b1, 5'd9,  ADDI, O_NONE};
      vecs[12] = '{1'b1, 5'd1,  BGEZ, O_BR};
      vecs[13] = '{1'b0, 5'd0,  BLEZ, O_BR};

      Reset = 1'b1; IDEX_MemRead = 1'b0; IDEX_rt = 5'd0;
      IFID_Instruction = NOP; EX_BranchResolved = 1'b0;
      @(posedge Clk);
      #1;

      // First-cycle response per vector, each preceded by a reset cycle
      // that must mask the hazard inputs.
      for (int i = 0; i < 14; i++) begin
         cyc(1'b1, vecs[i].mr, vecs[i].rt, vecs[i].ins, 1'b0, O_NONE, O_NONE, $sformatf("rst%0d", i));
         cyc(1'b0, vecs[i].mr, vecs[i].rt, vecs[i].ins, 1'b0, vecs[i].exp, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Load stall length; EX_BranchResolved ignored during LOAD_STALL.
      cyc(1'b1, 1'b0, 5'd0, NOP, 1'b0, O_NONE, O_NONE, "ld_rst");
      cyc(1'b0, 1'b1, 5'd8, ADD, 1'b0, O_LD,   O_LD,   "ld_c1");
      cyc(1'b0, 1'b0, 5'd0, ADD, 1'b1, O_NONE, O_LDB,  "ld_c2");
      cyc(1'b0, 1'b0, 5'd0, ADD, 1'b0, O_NONE, O_LDB,  "ld_c3");
      cyc(1'b0, 1'b0, 5'd0, ADD, 1'b0, O_NONE, O_NONE, "ld_c4");
`ifdef HAZARD_STATS_EN
      chk16("ld_stats_a", a_lsc, 16'd1);
      chk16("ld_stats_b", b_lsc, 16'd3);
      chk16("ld_bstats_b", b_bsc, 16'd0);
`endif

      // Branch runs to its full length.
      cyc(1'b1, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "br_rst");
      cyc(1'b0, 1'b0, 5'd0, BEQI, 1'b0, O_BR,   O_BR,   "br_c1");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_BRB,  O_BRB,  "br_c2");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_BRB,  "br_c3");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "br_c4");

      // Early release by EX_BranchResolved.
      cyc(1'b1, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "rel_rst");
      cyc(1'b0, 1'b0, 5'd0, BEQI, 1'b0, O_BR,   O_BR,   "rel_c1");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b1, O_REL,  O_REL,  "rel_c2");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "rel_c3");
`ifdef HAZARD_STATS_EN
      chk16("rel_bstats_b", b_bsc, 16'd1);
`endif

      // Load-dependent branch: load stall first, then branch sequence.
      cyc(1'b1, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "pri_rst");
      cyc(1'b0, 1'b1, 5'd9, BEQI, 1'b0, O_LD,   O_LD,   "pri_c1");
      cyc(1'b0, 1'b0, 5'd0, BEQI, 1'b0, O_BR,   O_LDB,  "pri_c2");
      cyc(1'b0, 1'b0, 5'd0, BEQI, 1'b0, O_BRB,  O_LDB,  "pri_c3");
      cyc(1'b0, 1'b0, 5'd0, BEQI, 1'b0, O_BR,   O_BR,   "pri_c4");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_BRB,  O_BRB,  "pri_c5");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_BRB,  "pri_c6");
      cyc(1'b0, 1'b0, 5'd0, NOP,  1'b0, O_NONE, O_NONE, "pri_c7");

      // Reset in the second stall cycle abandons the stall.
      cyc(1'b1, 1'b0, 5'd0, NOP, 1'b0, O_NONE, O_NONE, "mid_rst");
      cyc(1'b0, 1'b1, 5'd8, ADD, 1'b0, O_LD,   O_LD,   "mid_c1");
      cyc(1'b1, 1'b1, 5'd8, ADD, 1'b0, O_NONE, O_NONE, "mid_c2");
      cyc(1'b0, 1'b0, 5'd0, ADD, 1'b0, O_NONE, O_NONE, "mid_c3");
`ifdef HAZARD_STATS_EN
      chk16("mid_stats_a", a_lsc, 16'd0);
      chk16("mid_stats_b", b_lsc, 16'd0);
      chk16("mid_bstats_b", b_bsc, 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
